// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache that stalls the PC on a miss and fills a 4-word line.
// Optional hit/miss counters are enabled with ICACHE_STATS_EN.
module icache_fetch #(
   parameter int LINES = 16,
   parameter int IDX_W = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        pc_write_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);

   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            r_state;
   logic [1:0]        r_cnt;
   logic              r_abort;
   logic [27:0]       r_base;
   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [31:0]       r_data [LINES][4];

   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [1:0]        w_off;
   logic [IDX_W-1:0]  w_fidx;
   logic              w_hit;
   logic              w_lookup;
   logic              w_hit_ok;
   logic              w_miss;
   logic              w_wr;
   logic              w_last;

   assign w_idx    = pc_i[IDX_W+3:4];
   assign w_tag    = pc_i[31:IDX_W+4];
   assign w_off    = pc_i[3:2];
   assign w_fidx   = r_base[IDX_W-1:0];
   assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_lookup = (r_state == IDLE) && req_i;
   assign w_hit_ok = w_lookup && w_hit && !flush_i;
   assign w_miss   = w_lookup && !w_hit && !flush_i;
   assign w_wr     = (r_state == FILL) && mem_ack_i;
   assign w_last   = w_wr && (r_cnt == 2'd3);

   // A flush with a pending fetch wins over the hit so the lookup is retried as a miss.
   assign instr_valid_o = w_hit_ok;
   assign instr_o       = w_hit_ok ? r_data[w_idx][w_off] : 32'h0;
   assign pc_write_o    = (r_state == IDLE) && !(req_i && (!w_hit || flush_i));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_cnt      <= 2'd0;
         r_abort    <= 1'b0;
         r_valid    <= '0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= 32'h0;
`ifdef ICACHE_STATS_EN
         hit_cnt_o  <= 32'h0;
         miss_cnt_o <= 32'h0;
`endif
      end else begin
`ifdef ICACHE_STATS_EN
         if (w_hit_ok) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (w_miss)   miss_cnt_o <= miss_cnt_o + 32'd1;
`endif
         case (r_state)
            IDLE: begin
               if (flush_i) begin
                  r_valid <= '0;
               end else if (w_miss) begin
                  r_state    <= FILL;
                  r_cnt      <= 2'd0;
                  r_abort    <= 1'b0;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= pc_i & 32'hFFFF_FFF0;
               end
            end
            FILL: begin
               // An aborted fill still drains all four handshakes; only the valid bit is withheld.
               if (flush_i) r_abort <= 1'b1;
               if (mem_ack_i) begin
                  r_cnt      <= r_cnt + 2'd1;
                  mem_addr_o <= {r_base, r_cnt + 2'd1, 2'b00};
                  if (r_cnt == 2'd3) begin
                     mem_req_o <= 1'b0;
                     r_state   <= DONE;
                     if (r_abort || flush_i) r_valid <= '0;
                     else                    r_valid[w_fidx] <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               if (flush_i) r_valid <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_miss) r_base <= pc_i[31:4];
      if (w_wr)   r_data[w_fidx][r_cnt] <= mem_data_i;
      if (w_last) r_tag[w_fidx] <= r_base[27:IDX_W];
   end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Instruction-fetch responder sitting behind the program counter register.
- Takes the current PC and returns the instruction word from a direct-mapped, read-only instruction cache.
- On a miss it stalls the PC by deasserting pc_write_o (wired to the PC's write-enable), fills a 4-word line from a multi-cycle instruction memory over a req/ack handshake, then releases the PC.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2.
- IDX_W, 4, log2(LINES); must be consistent with LINES.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- req_i  input  1  fetch enable from the pipeline start signal; 0 = no fetch.
- pc_i  input  32  fetch byte address from the PC; bits [1:0] ignored.
- flush_i  input  1  invalidate all lines (fence.i-style).
- instr_o  output  32  instruction word; 0 when instr_valid_o=0.
- instr_valid_o  output  1  instr_o valid this cycle.
- pc_write_o  output  1  PC write enable; 0 = hold PC.
- mem_req_o  output  1  memory word read request.
- mem_addr_o  output  32  word-aligned memory address, bits [1:0]=0.
- mem_ack_i  input  1  memory word accepted; mem_data_i valid this cycle.
- mem_data_i  input  32  memory read data.

Behaviour:
- Address split of pc_i: offset [3:2] (word in line), index [IDX_W+3:4], tag [31:IDX_W+4].
- Storage per line: valid bit, tag, 4 data words. Data lookup is combinational (array read, no output register).
- Reset (async, rst_i=1): all valid bits 0, state IDLE, word counter 0, abort flag 0, mem_req_o=0, mem_addr_o=0. Data/tag arrays are not reset.
- Output values during reset (req_i=0): instr_valid_o=0, instr_o=0, pc_write_o=1.
- FSM states: IDLE, FILL, DONE.
- IDLE, req_i=0: pc_write_o=1, instr_valid_o=0, no memory activity.
- IDLE, req_i=1, hit (valid and tag match): instr_o = line word[offset], instr_valid_o=1, pc_write_o=1, all in the same cycle. Hit latency 0 cycles.
- IDLE, req_i=1, miss: pc_write_o=0, instr_valid_o=0. Next edge: latch the line base {pc_i[31:4],4'b0}, counter=0, go to FILL.
- FILL:
  - mem_req_o=1; mem_addr_o = base + 4*counter.
  - Address and request are held stable until mem_ack_i.
  - On each ack: write mem_data_i to word[counter] and increment counter.
  - Ack with counter=3: write tag, set valid (unless aborted), drop mem_req_o, go to DONE.
  - pc_write_o=0 and instr_valid_o=0 throughout FILL.
- DONE: one bubble cycle, pc_write_o=0, then return to IDLE. The held pc_i now hits.
- Miss penalty: 4 memory handshakes + 2 cycles.
- pc_i stays stable during the stall because the PC is frozen. The fill uses only the latched base, so a pc_i change mid-fill does not corrupt it.
- flush_i in IDLE: all valid bits are cleared at the next edge.
- flush_i in IDLE takes priority over a same-cycle hit: instr_valid_o=0, pc_write_o=0 that cycle, and the lookup repeats next cycle as a miss.
- flush_i during FILL:
  - Set the abort flag.
  - Complete the remaining word handshakes; a request is never withdrawn once raised.
  - Do not set valid; clear all valid bits; go to DONE.
- req_i dropped during FILL: the fill still completes normally.
- Reset mid-FILL: FSM returns to IDLE and mem_req_o drops immediately (asynchronous). The memory model must tolerate an abandoned request.
- Counter is 2 bits. Line base addresses wrap naturally at 2^32.
- Each line is filled by exactly 4 acks, with no gaps in the addresses issued.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds output ports hit_cnt_o[31:0] and miss_cnt_o[31:0], reset to 0.
  - hit_cnt_o increments once per cycle in IDLE with req_i=1, hit, and no flush.
  - miss_cnt_o increments once per IDLE-to-FILL transition.
  - Both wrap modulo 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Cold miss: rst_i pulse, req_i=1, pc_i=0x0000_0040, memory acks 2 cycles after each request with data=addr^0xA5A5_0000.
  - Required: mem_addr_o sequence 0x40, 0x44, 0x48, 0x4C.
  - Required: pc_write_o=0 until DONE has passed, then instr_o=0xA5A5_0040 with instr_valid_o=1.
- Hit: after the cold fill, pc_i=0x48 → same cycle instr_o=0xA5A5_0048, instr_valid_o=1, pc_write_o=1, mem_req_o=0.
- Conflict: pc_i=0x140 (same index 4, different tag) → miss and refill. Then pc_i=0x40 → miss again.
- Flush mid-fill: assert flush_i during the second word of a fill.
  - Required: all 4 acks still consumed, mem_req_o=0 afterwards.
  - Required: re-presenting the same PC misses.
- Async reset mid-fill: rst_i=1 between clock edges → mem_req_o=0 and pc_write_o=1 immediately; the next fetch of a previously cached PC misses.
- Stats (ICACHE_STATS_EN): 1 cold miss followed by 3 hits → miss_cnt_o=1, hit_cnt_o=3.
